// File: rtl/dynamic_serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// dynamic_serial_subtractor_if
//   Groups the operand-side and result-side handshakes of the serial
//   subtractor into one bundle.
//   Operand side : in_valid, in_ready, sum[S_W-1:0], a[A_W-1:0]
//   Result side  : out_valid, out_ready, diff[S_W-2:0], size[1:0], underflow
//   master modport : the producer/consumer that talks to the subtractor
//   slave modport  : the subtractor itself
// ---------------------------------------------------------------------------
interface dynamic_serial_subtractor_if #(
    parameter int A_W = 8,
    parameter int S_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [S_W-1:0]   sum;
    logic [A_W-1:0]   a;
    logic             out_valid;
    logic             out_ready;
    logic [S_W-2:0]   diff;
    logic [1:0]       size;
    logic             underflow;

    modport master (
        output in_valid, sum, a, out_ready,
        input  in_ready, out_valid, diff, size, underflow
    );

    modport slave (
        input  in_valid, sum, a, out_ready,
        output in_ready, out_valid, diff, size, underflow
    );
endinterface

// File: rtl/dynamic_serial_subtractor.sv
// ---------------------------------------------------------------------------
// dynamic_serial_subtractor
//   Recovers b = sum - a one bit per clock along an LSB-first ripple-borrow
//   chain. An accepted operation always takes S_W clocks of subtraction, then
//   the result is held in DONE until the consumer takes it.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of dynamic_serial_subtractor_if
//            (in_valid/in_ready/sum/a, out_valid/out_ready/diff/size/underflow)
// ---------------------------------------------------------------------------
module dynamic_serial_subtractor #(
    parameter int A_W = 8,
    parameter int S_W = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dynamic_serial_subtractor_if.slave    bus
);
    localparam int CNT_W = $clog2(S_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [S_W-1:0]     s_q;
    logic [S_W-1:0]     a_q;
    logic [S_W-1:0]     res_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [S_W-2:0]     diff_q;
    logic [1:0]         size_q;
    logic               underflow_q;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_s;
    logic               last_s;
    logic               bit_s;
    logic               borrow_s;
    logic [S_W-1:0]     result_s;

    // Size class of the recovered operand: top set bit among diff[9:8].
    function automatic logic [1:0] size_of(input logic [S_W-2:0] d);
        logic [1:0] r;
        if (d[S_W-2]) begin
            r = 2'b10;
        end else if (d[S_W-3]) begin
            r = 2'b01;
        end else begin
            r = 2'b00;
        end
        return r;
    endfunction

    // Handshake qualifiers and the single-bit full subtractor of the chain.
    always_comb begin
        accept_s = bus.in_valid && in_ready_q && (state_q == ST_IDLE);
        last_s   = (state_q == ST_SUB) && (cnt_q == CNT_W'(S_W - 1));
        bit_s    = s_q[0] ^ a_q[0] ^ borrow_q;
        borrow_s = (~s_q[0] & a_q[0]) | (~(s_q[0] ^ a_q[0]) & borrow_q);
        // The newest bit enters at the MSB, so after S_W shifts bit 0 sits at the LSB.
        result_s = {bit_s, res_q[S_W-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SUB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SUB;
                end
            end
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the handshake flops change together with state_q.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
            ST_SUB: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
            ST_DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Serial datapath: load on accept, shift one bit per clock while subtracting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= {S_W{1'b0}};
            a_q      <= {S_W{1'b0}};
            res_q    <= {S_W{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            s_q      <= bus.sum;
            a_q      <= {{(S_W-A_W){1'b0}}, bus.a};
            res_q    <= {S_W{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (state_q == ST_SUB) begin
            s_q      <= {1'b0, s_q[S_W-1:1]};
            a_q      <= {1'b0, a_q[S_W-1:1]};
            res_q    <= result_s;
            borrow_q <= borrow_s;
            cnt_q    <= cnt_q + CNT_W'(1);
        end else begin
            s_q      <= s_q;
            a_q      <= a_q;
            res_q    <= res_q;
            borrow_q <= borrow_q;
            cnt_q    <= cnt_q;
        end
    end

    // Result registers: loaded on the final subtraction edge, held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q      <= {(S_W-1){1'b0}};
            size_q      <= 2'b00;
            underflow_q <= 1'b0;
        end else if (last_s) begin
            diff_q      <= result_s[S_W-2:0];
            size_q      <= size_of(result_s[S_W-2:0]);
            // Final borrow means sum < a; a set top bit means b does not fit in S_W-1 bits.
            underflow_q <= borrow_s | result_s[S_W-1];
        end else begin
            diff_q      <= diff_q;
            size_q      <= size_q;
            underflow_q <= underflow_q;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.size      = size_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_dynamic_serial_subtractor.sv
module tb_dynamic_serial_subtractor;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dynamic_serial_subtractor_if #(.A_W(8), .S_W(11)) bus ();

    dynamic_serial_subtractor #(.A_W(8), .S_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] sum;
        logic [7:0]  a;
        logic [9:0]  diff;
        logic [1:0]  size;
        logic        uf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one operation, wait for out_valid; reports latency and in_ready violations.
    task automatic launch(input logic [10:0] s, input logic [7:0] av,
                          output int lat, output int ir_bad);
        @(negedge clk);
        bus.sum      = s;
        bus.a        = av;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sum      = 11'h5A5;
        bus.a        = 8'hC3;
        lat    = 0;
        ir_bad = (bus.in_ready !== 1'b0) ? 1 : 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.in_ready !== 1'b0) ir_bad++;
        end
    endtask

    task automatic complete();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovalid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("iready_back", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [10:0] s, input logic [7:0] av,
                           input logic [9:0] ed, input logic [1:0] es, input logic eu);
        int lat;
        int irb;
        launch(s, av, lat, irb);
        check({name, "_latency"}, lat, 32'd11);
        check({name, "_iready_low"}, irb, 32'd0);
        check({name, "_diff"}, {22'd0, bus.diff}, {22'd0, ed});
        check({name, "_size"}, {30'd0, bus.size}, {30'd0, es});
        check({name, "_uf"}, {31'd0, bus.underflow}, {31'd0, eu});
        complete();
    endtask

    function automatic logic [1:0] ref_size(input logic [9:0] d);
        if (d[9]) return 2'b10;
        else if (d[8]) return 2'b01;
        else return 2'b00;
    endfunction

    initial begin
        int lat;
        int irb;
        logic [9:0]  hold_d;
        logic [1:0]  hold_s;
        logic        hold_u;
        logic [11:0] full;
        logic [9:0]  rb;
        logic [7:0]  ra;
        logic [10:0] rs;

        total = 0;
        bad   = 0;
        vecs[0] = '{11'h4FE, 8'hFF, 10'h3FF, 2'b10, 1'b0};
        vecs[1] = '{11'h00C, 8'h05, 10'h007, 2'b00, 1'b0};
        vecs[2] = '{11'h110, 8'h10, 10'h100, 2'b01, 1'b0};
        vecs[3] = '{11'h010, 8'h20, 10'h3F0, 2'b10, 1'b1};
        vecs[4] = '{11'h7FF, 8'h00, 10'h3FF, 2'b10, 1'b1};
        vecs[5] = '{11'h0AB, 8'hAB, 10'h000, 2'b00, 1'b0};
        vecs[6] = '{11'h400, 8'h01, 10'h3FF, 2'b10, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum       = 11'h000;
        bus.a         = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_diff", {22'd0, bus.diff}, 32'd0);
        check("rst_size", {30'd0, bus.size}, 32'd0);
        check("rst_uf", {31'd0, bus.underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].sum, vecs[i].a,
                    vecs[i].diff, vecs[i].size, vecs[i].uf);
        end

        // Result stays visible in IDLE after the handshake (last vec: 0x3FF).
        check("idle_hold_diff", {22'd0, bus.diff}, 32'h3FF);

        // Backpressure: result held, in_valid ignored while in DONE.
        launch(11'h110, 8'h10, lat, irb);
        check("bp_latency", lat, 32'd11);
        hold_d = bus.diff;
        hold_s = bus.size;
        hold_u = bus.underflow;
        check("bp_diff", {22'd0, hold_d}, 32'h100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = (c == 2) ? 1'b1 : 1'b0;
            bus.sum      = 11'h7FF;
            bus.a        = 8'h01;
            @(posedge clk);
            #1;
            check("bp_ovalid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_iready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_stable", {19'd0, bus.diff, bus.size, bus.underflow},
                  {19'd0, hold_d, hold_s, hold_u});
        end
        bus.in_valid = 1'b0;
        complete();
        repeat (13) @(posedge clk);
        #1;
        check("bp_no_accept", {31'd0, bus.out_valid}, 32'd0);
        check("bp_diff_kept", {22'd0, bus.diff}, 32'h100);

        // Reset mid-operation.
        @(negedge clk);
        bus.sum      = 11'h4FE;
        bus.a        = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_iready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_outs", {19'd0, bus.diff, bus.size, bus.underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_rst", 11'h00C, 8'h05, 10'h007, 2'b00, 1'b0);

        // Random operations against an arithmetic reference.
        for (int r = 0; r < 24; r++) begin
            rb   = 10'($urandom_range(0, 1023));
            ra   = 8'($urandom_range(0, 255));
            rs   = (r % 4 == 3) ? 11'($urandom_range(0, 2047)) : ({1'b0, rb} + {3'b000, ra});
            full = {1'b0, rs} - {4'b0000, ra};
            run_vec($sformatf("rnd%0d", r), rs, ra, full[9:0], ref_size(full[9:0]),
                    full[11] | full[10]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
